// File: rtl/br_local_rx.sv
// BrLite local receive endpoint: four-phase capture from the router local port,
// filtering and dispatch to a PE FIFO, a latest-value monitor register and a clear counter.
package br_pkg;
    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_MON   = 2'd2,
        BR_SVC_CLEAR = 2'd3
    } br_svc_e;

    typedef struct packed {
        br_svc_e     service;
        logic [15:0] seq_source;
        logic [15:0] seq_target;
        logic [15:0] seq_id;
        logic [12:0] flags;
        logic [31:0] payload;
    } br_data_t;
endpackage

module br_local_rx
    import br_pkg::*;
#(
    parameter logic [15:0] LOCAL_ADDR = 16'h0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          DROP_SELF  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  br_data_t    data_i,
    output logic        ack_o,
    output logic        pe_valid_o,
    input  logic        pe_ready_i,
    output br_data_t    pe_data_o,
    output logic        mon_valid_o,
    input  logic        mon_ack_i,
    output br_data_t    mon_data_o,
    output logic        mon_ovf_o,
    output logic [7:0]  clear_cnt_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;
    typedef enum logic {S_IDLE, S_ACK} state_e;

    state_e     state_q, state_d;
    ptr_t       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    br_data_t   fifo_mem_q [FIFO_DEPTH];
    br_data_t   mon_data_q, mon_data_d;
    logic       mon_valid_q, mon_valid_d;
    logic       mon_ovf_q, mon_ovf_d;
    logic [7:0] clear_cnt_q, clear_cnt_d;

    logic to_fifo, full, empty, pop, room, accept, push, mon_wr, clr;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && pe_ready_i;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    assign room  = !full || pop;

    always_comb begin
        to_fifo = 1'b0;
        unique case (data_i.service)
            BR_SVC_ALL: to_fifo = !(DROP_SELF && (data_i.seq_source == LOCAL_ADDR));
            BR_SVC_TGT: to_fifo = (data_i.seq_target == LOCAL_ADDR);
            default:    to_fifo = 1'b0;
        endcase
    end

    assign accept = (state_q == S_IDLE) && req_i && (!to_fifo || room);
    assign push   = accept && to_fifo;
    assign mon_wr = accept && (data_i.service == BR_SVC_MON);
    assign clr    = accept && (data_i.service == BR_SVC_CLEAR);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mon_data_d  = mon_data_q;
        mon_valid_d = mon_valid_q;
        mon_ovf_d   = mon_ovf_q;
        clear_cnt_d = clear_cnt_q;

        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ACK;
            S_ACK:   if (!req_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
        if (clr)  clear_cnt_d = clear_cnt_q + 8'd1;

        if (mon_ack_i) begin
            mon_valid_d = 1'b0;
            mon_ovf_d   = 1'b0;
        end
        if (mon_wr) begin
            mon_data_d  = data_i;
            mon_valid_d = 1'b1;
            mon_ovf_d   = mon_ack_i ? 1'b0 : (mon_ovf_q || mon_valid_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mon_data_q  <= '0;
            mon_valid_q <= 1'b0;
            mon_ovf_q   <= 1'b0;
            clear_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mon_data_q  <= mon_data_d;
            mon_valid_q <= mon_valid_d;
            mon_ovf_q   <= mon_ovf_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    // NOTE: storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign ack_o       = (state_q == S_ACK);
    assign pe_valid_o  = !empty;
    assign pe_data_o   = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign mon_valid_o = mon_valid_q;
    assign mon_data_o  = mon_data_q;
    assign mon_ovf_o   = mon_ovf_q;
    assign clear_cnt_o = clear_cnt_q;
endmodule

// File: tb/tb_br_local_rx.sv
// Directed bench for br_local_rx: FIFO-bound packets go through a scoreboard queue,
// monitor/counter/handshake behaviour is checked against bench-side constants.
module tb_br_local_rx;
    import br_pkg::*;

    logic       clk, rst;
    logic       req, ack, pe_valid, pe_ready, mon_valid, mon_ack, mon_ovf;
    br_data_t   data, pe_data, mon_data;
    logic [7:0] clear_cnt;

    logic       req2, ack2, pe_valid2, pe_ready2, mon_valid2, mon_ovf2, mon_ack2;
    br_data_t   data2, pe_data2, mon_data2;
    logic [7:0] clear_cnt2;

    int errors = 0;
    int checks = 0;
    br_data_t sb[$];

    localparam logic [15:0] LADDR = 16'h0102;

    br_local_rx #(.LOCAL_ADDR(LADDR), .FIFO_DEPTH(4), .DROP_SELF(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .ack_o(ack),
        .pe_valid_o(pe_valid), .pe_ready_i(pe_ready), .pe_data_o(pe_data),
        .mon_valid_o(mon_valid), .mon_ack_i(mon_ack), .mon_data_o(mon_data),
        .mon_ovf_o(mon_ovf), .clear_cnt_o(clear_cnt)
    );

    br_local_rx #(.LOCAL_ADDR(LADDR), .FIFO_DEPTH(4), .DROP_SELF(1'b0)) u_dut_keep (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .data_i(data2), .ack_o(ack2),
        .pe_valid_o(pe_valid2), .pe_ready_i(pe_ready2), .pe_data_o(pe_data2),
        .mon_valid_o(mon_valid2), .mon_ack_i(mon_ack2), .mon_data_o(mon_data2),
        .mon_ovf_o(mon_ovf2), .clear_cnt_o(clear_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [94:0] obs, input logic [94:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic br_data_t mk(input br_svc_e s, input logic [15:0] src,
                                    input logic [15:0] tgt, input logic [31:0] pl);
        br_data_t p;
        p.service    = s;
        p.seq_source = src;
        p.seq_target = tgt;
        p.seq_id     = pl[15:0] ^ 16'h55AA;
        p.flags      = 13'h0A5;
        p.payload    = pl;
        return p;
    endfunction

    task automatic wait_ack_low(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (ack !== 1'b0 && n < 4);
        check(tag, 95'(n), 95'd1);
    endtask

    // Drive one request, wait (bounded) for ack, optionally hold req, then release.
    task automatic send(input br_data_t p, input int hold, output int waited);
        req = 1'b1;
        data = p;
        waited = 0;
        do begin @(negedge clk); waited++; end while (ack !== 1'b1 && waited < 8);
        repeat (hold) @(negedge clk);
        req = 1'b0;
        wait_ack_low("ack_fall");
    endtask

    task automatic pop_check(input string tag);
        br_data_t exp;
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, "_valid"}, 95'(pe_valid), 95'd1);
        check(tag, pe_data, exp);
        pe_ready = 1'b1;
        @(negedge clk);
        pe_ready = 1'b0;
    endtask

    initial begin
        br_data_t p, p5, mon_c, x;
        int w, n_ack, bad;

        rst = 1'b1; req = 1'b0; data = '0; pe_ready = 1'b0; mon_ack = 1'b0;
        req2 = 1'b0; data2 = '0; pe_ready2 = 1'b0; mon_ack2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 95'(ack), 95'd0);
        check("rst_pe_valid", 95'(pe_valid), 95'd0);
        check("rst_mon_valid", 95'(mon_valid), 95'd0);
        check("rst_mon_ovf", 95'(mon_ovf), 95'd0);
        check("rst_clear_cnt", 95'(clear_cnt), 95'd0);
        check("rst_mon_data", mon_data, 95'd0);
        rst = 1'b0;
        @(negedge clk);

        // Target filtering
        p = mk(BR_SVC_TGT, 16'h0007, LADDR, 32'hCAFE0001);
        send(p, 0, w);
        check("tgt_hit_ack_latency", 95'(w), 95'd1);
        sb.push_back(p);
        send(mk(BR_SVC_TGT, 16'h0007, 16'h0203, 32'hDEAD0002), 0, w);
        check("tgt_miss_ack_latency", 95'(w), 95'd1);
        pop_check("tgt_head");
        check("tgt_miss_not_stored", 95'(pe_valid), 95'd0);

        // Self drop, and the same packet kept when DROP_SELF=0
        p = mk(BR_SVC_ALL, LADDR, 16'h0000, 32'h5E1F0003);
        send(p, 0, w);
        check("self_ack_latency", 95'(w), 95'd1);
        check("self_dropped", 95'(pe_valid), 95'd0);
        req2 = 1'b1; data2 = p; w = 0;
        do begin @(negedge clk); w++; end while (ack2 !== 1'b1 && w < 8);
        check("keep_ack_latency", 95'(w), 95'd1);
        req2 = 1'b0;
        @(negedge clk);
        check("keep_ack_fall", 95'(ack2), 95'd0);
        check("keep_stored", 95'(pe_valid2), 95'd1);
        check("keep_data", pe_data2, p);

        // Backpressure and wrap-around ordering
        for (int i = 0; i < 4; i++) begin
            p = mk(BR_SVC_ALL, 16'h0300 + 16'(i), 16'h0000, 32'hB0000000 + 32'(i));
            send(p, 0, w);
            check("bp_fill_ack", 95'(w), 95'd1);
            sb.push_back(p);
        end
        p5 = mk(BR_SVC_ALL, 16'h0304, 16'h0000, 32'hB0000004);
        req = 1'b1; data = p5; n_ack = 0;
        repeat (4) begin @(negedge clk); if (ack === 1'b1) n_ack++; end
        check("bp_full_no_ack", 95'(n_ack), 95'd0);
        pop_check("bp_pulse_head");
        sb.push_back(p5);
        w = 1;
        while (ack !== 1'b1 && w < 2) begin @(negedge clk); w++; end
        check("bp_ack_after_pop", 95'(ack), 95'd1);
        req = 1'b0;
        wait_ack_low("bp_ack_fall");
        for (int i = 0; i < 4; i++) pop_check("bp_drain");
        check("bp_empty", 95'(pe_valid), 95'd0);

        // Monitor overflow and same-cycle ack/write
        send(mk(BR_SVC_MON, 16'h0011, 16'h0000, 32'hA0000001), 0, w);
        check("mon_a_valid", 95'(mon_valid), 95'd1);
        check("mon_a_ovf", 95'(mon_ovf), 95'd0);
        p = mk(BR_SVC_MON, 16'h0012, 16'h0000, 32'hA0000002);
        send(p, 0, w);
        check("mon_b_data", mon_data, p);
        check("mon_b_ovf", 95'(mon_ovf), 95'd1);
        mon_c = mk(BR_SVC_MON, 16'h0013, 16'h0000, 32'hA0000003);
        req = 1'b1; data = mon_c; mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
        check("mon_c_ack", 95'(ack), 95'd1);
        check("mon_c_valid", 95'(mon_valid), 95'd1);
        check("mon_c_ovf", 95'(mon_ovf), 95'd0);
        check("mon_c_data", mon_mon_data_fix(mon_data), mon_c);
        req = 1'b0;
        wait_ack_low("mon_c_ack_fall");
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
        check("mon_ack_clears_valid", 95'(mon_valid), 95'd0);
        check("mon_not_in_fifo", 95'(pe_valid), 95'd0);

        // Clear counter: first request held high for 5 cycles, then 256 more
        send(mk(BR_SVC_CLEAR, 16'h0020, 16'h0000, 32'h0), 5, w);
        check("clr_held_ack", 95'(w), 95'd1);
        check("clr_held_once", 95'(clear_cnt), 95'd1);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(mk(BR_SVC_CLEAR, 16'h0020, 16'h0000, 32'(i)), 0, w);
            if (w != 1) bad++;
        end
        check("clr_ack_latency_all", 95'(bad), 95'd0);
        check("clr_wrap", 95'(clear_cnt), 95'd1);
        check("clr_fifo_empty", 95'(pe_valid), 95'd0);

        // Reset in ACK with two FIFO entries
        for (int i = 0; i < 2; i++) begin
            p = mk(BR_SVC_ALL, 16'h0400 + 16'(i), 16'h0000, 32'hC0000000 + 32'(i));
            send(p, 0, w);
            sb.push_back(p);
        end
        x = mk(BR_SVC_ALL, 16'h0499, 16'h0000, 32'hC00000FF);
        req = 1'b1; data = x;
        @(negedge clk);
        check("rstmid_in_ack", 95'(ack), 95'd1);
        rst = 1'b1;
        #1;
        check("rstmid_ack", 95'(ack), 95'd0);
        check("rstmid_pe_valid", 95'(pe_valid), 95'd0);
        check("rstmid_clear_cnt", 95'(clear_cnt), 95'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_recapture_ack", 95'(ack), 95'd1);
        sb.push_back(x);
        req = 1'b0;
        wait_ack_low("rstmid_ack_fall");
        pop_check("rstmid_head");
        check("rstmid_empty", 95'(pe_valid), 95'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic br_data_t mon_mon_data_fix(input br_data_t d);
        return d;
    endfunction
endmodule

// File: doc/br_local_rx.md
# br_local_rx

Receive endpoint for the BrLite broadcast network: accepts `br_data_t` packets from a router's local output port over a four-phase req/ack handshake. It filters each packet by service and addressing and decodes it into one of three destinations:
- a FIFO for the processing element (PE);
- a latest-value monitor register;
- an internal clear counter.

It sits between the router local port and the PE/network-interface logic. It is the consumer counterpart of the local injection path.

## Interface
Parameters:
- `LOCAL_ADDR`, 16'h0000: this tile's 16-bit address, compared against `seq_target` and `seq_source`.
- `FIFO_DEPTH`, 4: PE FIFO entries. Must be a power of 2, ≥2.
- `DROP_SELF`, 1: when 1, BR_SVC_ALL packets with `seq_source == LOCAL_ADDR` are discarded.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  router presents a packet; held until `ack_o` is seen, then dropped.
- `data_i`  in  `$bits(br_data_t)` (95)  packet, stable while `req_i`=1.
- `ack_o`  out  1  four-phase acknowledge.
- `pe_valid_o`  out  1  FIFO head valid.
- `pe_ready_i`  in  1  PE pops the head when `pe_valid_o`=1.
- `pe_data_o`  out  95  FIFO head packet, `br_data_t`.
- `mon_valid_o`  out  1  monitor register holds an unread packet.
- `mon_ack_i`  in  1  clears `mon_valid_o` and `mon_ovf_o`.
- `mon_data_o`  out  95  last accepted BR_SVC_MON packet.
- `mon_ovf_o`  out  1  sticky flag: a MON packet overwrote an unread one.
- `clear_cnt_o`  out  8  count of BR_SVC_CLEAR packets received, wraps 255→0.

## Operation
Classification is combinational on `data_i.service`:
- **ALL**: pushed to the FIFO. When `DROP_SELF` and `seq_source == LOCAL_ADDR`, the packet is discarded instead (acked, not stored).
- **TGT**: pushed to the FIFO if `seq_target == LOCAL_ADDR`, else discarded (acked).
- **MON**: written to the monitor register. It is never blocked.
  - If `mon_valid_o` was already 1 and `mon_ack_i` is not asserted in the same cycle, set `mon_ovf_o`.
- **CLEAR**: `clear_cnt_o` increments by 1; the packet is not stored.

Capture FSM, states IDLE and ACK:
- **IDLE**:
  - If `req_i`=1 and the packet is acceptable, perform the action above on this edge and go to ACK.
  - "Acceptable" means any destination except the FIFO, or the FIFO with room.
  - A FIFO-bound packet with the FIFO full stays in IDLE without an ack (backpressure). It is retried every cycle.
  - Room is evaluated including a same-cycle pop, so a full FIFO with `pe_ready_i`=1 accepts.
- **ACK**:
  - `ack_o`=1.
  - Remain while `req_i`=1. On `req_i`=0 go to IDLE.
  - No capture occurs in ACK, so one request produces exactly one action.

FIFO behaviour:
- Circular buffer with read/write pointers one bit wider than the index. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Simultaneous push and pop are both performed; occupancy is unchanged.
- `pe_data_o` is the head entry. It is only meaningful when `pe_valid_o`=1.

Monitor register behaviour:
- `mon_ack_i` clears `mon_valid_o` and `mon_ovf_o`.
- A MON write in the same cycle wins: `mon_valid_o` ends at 1 and `mon_ovf_o` ends at 0.

Reset (asynchronous, immediate):
- State goes to IDLE; `ack_o`=0, `pe_valid_o`=0, `mon_valid_o`=0, `mon_ovf_o`=0, `clear_cnt_o`=0.
- FIFO pointers go to 0; `mon_data_o`=0. FIFO storage is not reset.
- Reset in ACK drops `ack_o` immediately. After reset, a still-high `req_i` is treated as a new request.

## Timing
- Capture happens on the edge where the FSM is in IDLE and `req_i`=1. `ack_o` rises in the following cycle (registered).
- Push latency: `pe_valid_o` rises in the cycle after capture, if the FIFO was empty.
- `ack_o` falls one cycle after `req_i` is sampled low.
- Minimum packet period is 3 cycles (capture, ack, release). For example: `req_i` high in cycle 0, `ack_o` high in cycle 1, `req_i` low in cycle 1 or later, IDLE again in cycle 2 or later.
- Pop occurs on the edge where `pe_valid_o`=1 and `pe_ready_i`=1. The next head, or `pe_valid_o`=0, appears in the next cycle.
- `clear_cnt_o`, `mon_*` update in the cycle after capture.

## Test plan
- **ALL/TGT filter**: `LOCAL_ADDR`=16'h0102. Send TGT with `seq_target`=16'h0102, `payload`=32'hCAFE0001. Then send TGT with `seq_target`=16'h0203. Expected: both acked in the cycle after req; only the CAFE0001 packet appears on `pe_data_o`.
- **Backpressure**: `FIFO_DEPTH`=4, `pe_ready_i`=0. Send 5 ALL packets. Expected: 4 acked; 5th `req_i` held with `ack_o`=0. Pulse `pe_ready_i` for one cycle: 5th acked within 2 cycles; FIFO order preserved after wrap-around.
- **Self drop**: ALL with `seq_source`=`LOCAL_ADDR`. Expected: acked, `pe_valid_o` stays 0. Repeat with `DROP_SELF`=0: packet stored.
- **Monitor overflow**: two MON packets with no `mon_ack_i`. Expected: `mon_data_o` = second packet, `mon_ovf_o`=1. Assert `mon_ack_i` with a third MON in the same cycle: `mon_valid_o`=1, `mon_ovf_o`=0, data = third.
- **Clear counter**: 257 CLEAR packets. Expected: `clear_cnt_o`=1; FIFO empty; each acked exactly once even with `req_i` held high for 5 cycles.
- **Reset mid-handshake**: assert `rst_i` while in ACK with 2 FIFO entries. Expected: `ack_o`, `pe_valid_o`, `clear_cnt_o` all 0 immediately. After release with `req_i` still high, a new capture occurs and `ack_o` rises one cycle later.
